// File: rtl/fft_frame_packetizer.sv
// FFT output-stream packetizer: validates each frame, splits it into PKT_LEN-beat packets, each led by a header beat.
// Optional build macro FFT_PKT_ERRCNT_EN adds a saturating err_count output.
module fft_frame_packetizer #(
    parameter int FFT_LEN            = 8192,
    parameter int FFT_CHANNELS       = 2,
    parameter int FFT_AXI_DATA_WIDTH = 32,
    parameter int FFT_INDEX_LEN      = 32,
    parameter int PKT_LEN            = 256
) (
    input  logic                                       aclk,
    input  logic                                       aresetn,
    input  logic                                       enable,
    input  logic [FFT_CHANNELS*FFT_AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                                       s_axis_tvalid,
    input  logic                                       s_axis_tlast,
    output logic                                       s_axis_tready,
    input  logic [FFT_INDEX_LEN-1:0]                   s_index,
    output logic [FFT_CHANNELS*FFT_AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                                       m_axis_tvalid,
    output logic                                       m_axis_tlast,
    input  logic                                       m_axis_tready,
    output logic                                       frame_done,
    output logic                                       frame_err,
    output logic                                       busy
`ifdef FFT_PKT_ERRCNT_EN
    ,
    output logic [15:0]                                err_count
`endif
);

    localparam int DW = FFT_CHANNELS * FFT_AXI_DATA_WIDTH;
    localparam int SW = $clog2(FFT_LEN);
    localparam int PW = $clog2(PKT_LEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [SW-1:0] samp_cnt, samp_nxt;
    logic [PW-1:0] pkt_cnt, pkt_nxt;
    logic [15:0]   frame_cnt, fcnt_nxt;
    logic          idx_err, idx_err_nxt;

    logic          out_free;
    logic          s_accept;
    logic          idx_bad;
    logic          last_bin;
    logic          last_slot;
    logic [DW-1:0] hdr_word;

    logic          load_en;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          done_nxt;
    logic          err_nxt;

    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = ((state == ST_DATA) && out_free) || (state == ST_DROP);
    assign s_accept      = s_axis_tvalid && s_axis_tready;
    assign busy          = (state != ST_IDLE);

    assign idx_bad   = (s_index != FFT_INDEX_LEN'(samp_cnt));
    assign last_bin  = (samp_cnt == SW'(FFT_LEN - 1));
    assign last_slot = (pkt_cnt == PW'(PKT_LEN - 1));
    assign hdr_word  = DW'({16'hFF7A, frame_cnt, 32'(samp_cnt)});

    always_comb begin
        state_nxt   = state;
        samp_nxt    = samp_cnt;
        pkt_nxt     = pkt_cnt;
        fcnt_nxt    = frame_cnt;
        idx_err_nxt = idx_err;
        load_en     = 1'b0;
        load_data   = '0;
        load_last   = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (enable && s_axis_tvalid) begin
                    state_nxt   = ST_HDR;
                    samp_nxt    = '0;
                    pkt_nxt     = '0;
                    idx_err_nxt = 1'b0;
                end
            end
            ST_HDR: begin
                if (out_free) begin
                    load_en   = 1'b1;
                    load_data = hdr_word;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (s_accept) begin
                    load_en     = 1'b1;
                    load_data   = s_axis_tdata;
                    samp_nxt    = samp_cnt + 1'b1;
                    pkt_nxt     = pkt_cnt + 1'b1;
                    idx_err_nxt = idx_err || idx_bad;
                    // Frame-end cases take priority over packet end; only a clean tlast on the final bin can be good.
                    if (s_axis_tlast || last_bin) begin
                        load_last = 1'b1;
                        done_nxt  = 1'b1;
                        err_nxt   = !(s_axis_tlast && last_bin) || idx_err || idx_bad;
                        fcnt_nxt  = frame_cnt + 1'b1;
                        state_nxt = s_axis_tlast ? ST_IDLE : ST_DROP;
                    end else if (last_slot) begin
                        load_last = 1'b1;
                        pkt_nxt   = '0;
                        state_nxt = ST_HDR;
                    end
                end
            end
            default: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= ST_IDLE;
            samp_cnt      <= '0;
            pkt_cnt       <= '0;
            frame_cnt     <= '0;
            idx_err       <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            state      <= state_nxt;
            samp_cnt   <= samp_nxt;
            pkt_cnt    <= pkt_nxt;
            frame_cnt  <= fcnt_nxt;
            idx_err    <= idx_err_nxt;
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
            if (out_free) begin
                m_axis_tvalid <= load_en;
                if (load_en) begin
                    m_axis_tdata <= load_data;
                    m_axis_tlast <= load_last;
                end
            end
        end
    end

`ifdef FFT_PKT_ERRCNT_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_count <= '0;
        end else if (err_nxt && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule
